demux_4: RTL

- Registered 1-to-4 demultiplexer; the inverse of the 4-input word mux.
- Accepts one WIDTH-bit word per cycle on a valid/ready input and steers it to one of four output channels, chosen by select.
- Each output channel holds its word in a one-entry register until the downstream consumer accepts it.
- Sits between a single producer and four consumers in the datapath.

---
 rtl/demux_pkg.sv | 25 ++
 rtl/demux_slot.sv | 90 +++++++++
 rtl/demux_4.sv | 78 +++++++
 3 files changed

// File: rtl/demux_pkg.sv
// Shared definitions for the registered 1-to-4 demultiplexer.
package demux_pkg;

  localparam int NUM_CH = 4;

  // Channel indices, matching the encoding of the select input.
  localparam logic [1:0] CH_A = 2'b00;
  localparam logic [1:0] CH_B = 2'b01;
  localparam logic [1:0] CH_C = 2'b10;
  localparam logic [1:0] CH_D = 2'b11;

  // Occupancy of a one-entry output slot.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // One-hot decode of a channel index.
  function automatic logic [NUM_CH-1:0] ch_onehot(input logic [1:0] ch);
    logic [NUM_CH-1:0] one;
    one = {{(NUM_CH-1){1'b0}}, 1'b1};
    return one << ch;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One output channel: a one-entry word register, its occupancy state and a
// counter of words handed to the downstream consumer.
//
// Handshake: a word moves downstream on a rising edge where valid and
// out_ready are both high; a word moves in on a rising edge where load is
// high. load is only raised by the parent when can_load is high.
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [0:WIDTH-1]   load_data,
  input  logic               out_ready,
  output logic               valid,
  output logic [0:WIDTH-1]   data,
  output logic [CNT_W-1:0]   count,
  output logic               can_load,
  output slot_state_t        state
);

  slot_state_t        state_q;
  slot_state_t        state_d;
  logic [0:WIDTH-1]   data_q;
  logic [CNT_W-1:0]   count_q;
  logic               drain;

  // A transfer happens whenever a held word meets a ready consumer.
  assign drain    = (state_q == SLOT_FULL) && out_ready;

  // Room exists if empty, or if the held word leaves on this same edge.
  assign can_load = (state_q == SLOT_EMPTY) || out_ready;

  // Occupancy state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SLOT_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next occupancy: a load always leaves the slot full (including the
  // simultaneous drain-and-refill case); a drain without load empties it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SLOT_EMPTY: begin
        if (load) begin
          state_d = SLOT_FULL;
        end
      end
      SLOT_FULL: begin
        if (load) begin
          state_d = SLOT_FULL;
        end else if (out_ready) begin
          state_d = SLOT_EMPTY;
        end
      end
      default: state_d = SLOT_EMPTY;
    endcase
  end

  // Word register: captured on load, otherwise kept (not cleared on drain).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= load_data;
    end
  end

  // Delivered-word counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (drain) begin
      count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign valid = (state_q == SLOT_FULL);
  assign data  = data_q;
  assign count = count_q;
  assign state = state_q;

endmodule

// File: rtl/demux_4.sv
// Registered 1-to-4 demultiplexer: steers one input word per cycle to the
// output channel chosen by select, each channel holding its word until the
// consumer takes it.
//
// Handshake: the input transfers on a rising edge where in_valid and
// in_ready are both high; in_ready depends only on the channel addressed by
// select, so a stalled channel never blocks traffic to the others. Each
// output channel x transfers on a rising edge where out_valid[x] and
// out_ready[x] are both high.
module demux_4
  import demux_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [0:WIDTH-1]   in_data,
  input  logic [1:0]         select,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic [0:WIDTH-1]   out_data_a,
  output logic [0:WIDTH-1]   out_data_b,
  output logic [0:WIDTH-1]   out_data_c,
  output logic [0:WIDTH-1]   out_data_d,
  output logic [CNT_W-1:0]   count_a,
  output logic [CNT_W-1:0]   count_b,
  output logic [CNT_W-1:0]   count_c,
  output logic [CNT_W-1:0]   count_d
);

  logic [NUM_CH-1:0] sel_onehot;
  logic [NUM_CH-1:0] can_load;
  logic [NUM_CH-1:0] load;
  logic              accept;
  logic [0:WIDTH-1]  slot_data  [NUM_CH];
  logic [CNT_W-1:0]  slot_count [NUM_CH];
  slot_state_t       slot_state [NUM_CH];

  // Decode the destination and steer the accept strobe to that slot only.
  always_comb begin
    sel_onehot = ch_onehot(select);
    in_ready   = can_load[select];
    accept     = in_valid && in_ready;
    load       = accept ? sel_onehot : '0;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
    demux_slot #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (load[i]),
      .load_data (in_data),
      .out_ready (out_ready[i]),
      .valid     (out_valid[i]),
      .data      (slot_data[i]),
      .count     (slot_count[i]),
      .can_load  (can_load[i]),
      .state     (slot_state[i])
    );
  end

  assign out_data_a = slot_data[CH_A];
  assign out_data_b = slot_data[CH_B];
  assign out_data_c = slot_data[CH_C];
  assign out_data_d = slot_data[CH_D];

  assign count_a = slot_count[CH_A];
  assign count_b = slot_count[CH_B];
  assign count_c = slot_count[CH_C];
  assign count_d = slot_count[CH_D];

endmodule
